// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared definitions for the carry-lookahead accumulator.
//                Holds the FSM state encoding and the lookahead group width.
//  Contents    : cla_state_t   - 2-bit FSM state type
//                c_st_idle     - waiting for an operand (in_ready high)
//                c_st_add      - one-cycle add/subtract/clear
//                c_st_hold     - result presented (out_valid high)
//                CLA_GRP       - bits per carry-lookahead group (4)
//  Revision    : 1.0  initial release
// ============================================================================
package cla_pkg;

  // Bits per carry-lookahead group; the datapath is tiled in groups of this size.
  localparam int CLA_GRP = 4;

  // FSM state encoding.
  typedef logic [1:0] cla_state_t;

  localparam cla_state_t c_st_idle = 2'd0;
  localparam cla_state_t c_st_add  = 2'd1;
  localparam cla_state_t c_st_hold = 2'd2;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla4_carry.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_carry
//  Description : Purely combinational 4-bit carry-lookahead unit. Produces
//                all four group carries directly from the per-bit
//                generate/propagate terms and the group carry-in, so no
//                carry ripples inside the group.
//  Ports       : i_g[3:0]  - per-bit generate  (a & b)
//                i_p[3:0]  - per-bit propagate (a ^ b)
//                i_ci      - carry into bit 0 of the group
//                o_c1..o_c4- carries into bits 1..3 and out of bit 3
//  Revision    : 1.0  initial release
// ============================================================================
import cla_pkg::*;

module cla4_carry (
  input  logic [CLA_GRP-1:0] i_g,
  input  logic [CLA_GRP-1:0] i_p,
  input  logic               i_ci,
  output logic               o_c1,
  output logic               o_c2,
  output logic               o_c3,
  output logic               o_c4
);

  // Each carry is the OR of "generated at bit k and propagated through every
  // bit above k" terms, plus the carry-in propagated through all lower bits.
  assign o_c1 = i_g[0]
              | (i_p[0] & i_ci);

  assign o_c2 = i_g[1]
              | (i_p[1] & i_g[0])
              | (i_p[1] & i_p[0] & i_ci);

  assign o_c3 = i_g[2]
              | (i_p[2] & i_g[1])
              | (i_p[2] & i_p[1] & i_g[0])
              | (i_p[2] & i_p[1] & i_p[0] & i_ci);

  assign o_c4 = i_g[3]
              | (i_p[3] & i_g[2])
              | (i_p[3] & i_p[2] & i_g[1])
              | (i_p[3] & i_p[2] & i_p[1] & i_g[0])
              | (i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_ci);

endmodule : cla4_carry
`default_nettype wire

// File: rtl/cla_accum.sv
`default_nettype none
// ============================================================================
//  Module      : cla_accum
//  Description : Handshaked add/subtract accumulator built on 4-bit
//                carry-lookahead groups with ripple between groups.
//                One operation every three cycles: IDLE (accept) -> ADD
//                (update accumulator) -> HOLD (present result until taken).
//  Parameters  : WIDTH     - accumulator width, a multiple of 4 (default 8)
//  Ports       : clk       - clock, rising edge
//                rst_n     - synchronous active-low reset
//                in_valid  - operand offered
//                in_ready  - operand can be accepted (IDLE only)
//                in_op     - 0 = add, 1 = subtract
//                in_clr    - clear accumulator, in_data ignored
//                in_data   - operand
//                out_valid - result available (HOLD)
//                out_ready - consumer takes result
//                out_sum   - accumulator value
//                out_c     - MSB carry-out (subtract: 1 = no borrow)
//                out_v     - signed overflow
//  Macros      : CLA_SAT_EN - when defined, signed overflow saturates the
//                accumulator instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
import cla_pkg::*;

module cla_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic             in_clr,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v
);

  localparam int c_ngrp = WIDTH / CLA_GRP;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  cla_state_t       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic             r_op;
  logic             r_clr;
  logic             r_c;
  logic             r_v;

  // --------------------------------------------------------------------------
  // Datapath: acc + b + cin, where subtract uses b = ~operand and cin = 1
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_load;

  assign w_b        = r_op ? ~r_opnd : r_opnd;
  assign w_g        = r_acc & w_b;
  assign w_p        = r_acc ^ w_b;
  assign w_carry[0] = r_op;

  // Each group resolves its four carries in parallel; the group carry-out
  // ripples into the next group's carry-in.
  generate
    for (genvar gi = 0; gi < c_ngrp; gi++) begin : g_grp
      cla4_carry u_cla4_carry (
        .i_g  (w_g[gi*CLA_GRP +: CLA_GRP]),
        .i_p  (w_p[gi*CLA_GRP +: CLA_GRP]),
        .i_ci (w_carry[gi*CLA_GRP]),
        .o_c1 (w_carry[gi*CLA_GRP + 1]),
        .o_c2 (w_carry[gi*CLA_GRP + 2]),
        .o_c3 (w_carry[gi*CLA_GRP + 3]),
        .o_c4 (w_carry[gi*CLA_GRP + 4])
      );
    end
  endgenerate

  assign w_sum  = w_p ^ w_carry[WIDTH-1:0];
  assign w_cout = w_carry[WIDTH];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign w_ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];

`ifdef CLA_SAT_EN
  // On overflow the effective operands shared a sign. A clear MSB carry-out
  // means both were non-negative (positive overflow), a set one means both
  // were negative (negative overflow).
  assign w_load = !w_ovf ? w_sum
                : (w_cout ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign w_load = w_sum;
`endif

  // --------------------------------------------------------------------------
  // Control FSM and registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_op    <= 1'b0;
      r_clr   <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_opnd  <= in_data;
            r_op    <= in_op;
            r_clr   <= in_clr;
            r_state <= c_st_add;
          end
        end

        c_st_add: begin
          if (r_clr) begin
            r_acc <= '0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
          end else begin
            r_acc <= w_load;
            r_c   <= w_cout;
            r_v   <= w_ovf;
          end
          r_state <= c_st_hold;
        end

        // Entered only from ADD, so HOLD always lasts at least one cycle.
        c_st_hold: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end

        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == c_st_idle);
  assign out_valid = (r_state == c_st_hold);
  assign out_sum   = r_acc;
  assign out_c     = r_c;
  assign out_v     = r_v;

endmodule : cla_accum
`default_nettype wire

// File: tb/tb_cla_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_accum
//  Description : Directed self-checking bench for cla_accum (WIDTH = 8).
//                Expected values are hand-computed; CLA_SAT_EN selects the
//                saturating expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_accum;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_op;
  logic       in_clr;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_c;
  logic       out_v;

  int n_checks = 0;
  int n_pass   = 0;

  cla_accum #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_clr    (in_clr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_c     (out_c),
    .out_v     (out_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand, check out_valid stays low on the ADD cycle and the
  // result appears on the following edge. Leaves the DUT in HOLD.
  task automatic run_op(input string tag, input logic op, input logic clr,
                        input logic [7:0] data, input logic [7:0] e_sum,
                        input logic e_c, input logic e_v);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_clr   = clr;
    in_data  = data;
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_op    = 1'($urandom);
    in_clr   = 1'($urandom);
    check({tag, "_addvalid"}, out_valid, 0);
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"},   out_sum,   e_sum);
    check({tag, "_c"},     out_c,     e_c);
    check({tag, "_v"},     out_v,     e_v);
  endtask

  // Take the result: HOLD exits on the first edge with out_ready high.
  task automatic release_op(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, out_valid, 0);
    check({tag, "_rel_ready"}, in_ready,  1);
  endtask

  initial begin
    logic [7:0] e_povf;
    logic [7:0] e_novf;
`ifdef CLA_SAT_EN
    e_povf = 8'h7F;
    e_novf = 8'h80;
`else
    e_povf = 8'h80;
    e_novf = 8'h7F;
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_clr    = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    check("rst_sum",   out_sum,   0);
    check("rst_c",     out_c,     0);
    check("rst_v",     out_v,     0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready,  1);
    rst_n = 1'b1;
    step();

    // Basic add and build-up to 0x7F
    run_op("add05", 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0);
    release_op("add05");
    run_op("add7a", 1'b0, 1'b0, 8'h7A, 8'h7F, 1'b0, 1'b0);
    release_op("add7a");

    // Positive overflow, then reset while in HOLD
    run_op("povf", 1'b0, 1'b0, 8'h01, e_povf, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("hrst_sum",   out_sum,   0);
    check("hrst_c",     out_c,     0);
    check("hrst_v",     out_v,     0);
    check("hrst_valid", out_valid, 0);
    check("hrst_ready", in_ready,  1);

    // Subtract borrow, clear, carry-out wrap
    run_op("sub01", 1'b1, 1'b0, 8'h01, 8'hFF, 1'b0, 1'b0);
    release_op("sub01");
    run_op("clr1", 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0);
    release_op("clr1");
    run_op("addff", 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    release_op("addff");
    run_op("wrap", 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0);
    release_op("wrap");
    run_op("clr2", 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0);
    release_op("clr2");

    // HOLD stall with inputs toggling; nothing may be accepted
    run_op("add33", 1'b0, 1'b0, 8'h33, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_data  = 8'($urandom);
      step();
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready,  0);
      check("stall_sum",   out_sum,   8'h33);
    end
    in_valid = 1'b0;
    release_op("stall");
    check("stall_keep", out_sum, 8'h33);
    run_op("add01", 1'b0, 1'b0, 8'h01, 8'h34, 1'b0, 1'b0);
    release_op("add01");

    // Reset during ADD discards the pending operand
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_clr   = 1'b0;
    in_data  = 8'h10;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready,  1);
    check("arst_sum",   out_sum,   0);
    step();
    check("arst_idle", out_valid, 0);
    run_op("add02", 1'b0, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0);
    release_op("add02");

    // Negative overflow: 0x81 - 0x02
    run_op("clr3", 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    release_op("clr3");
    run_op("sub7f", 1'b1, 1'b0, 8'h7F, 8'h81, 1'b0, 1'b0);
    release_op("sub7f");
    run_op("novf", 1'b1, 1'b0, 8'h02, e_novf, 1'b1, 1'b1);
    release_op("novf");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cla_accum
`default_nettype wire
